// File: rtl/lam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lam_pkg
// Description : Shared definitions for the load/store memory unit: direction
//               bit values, funct3 codes, FSM state encoding and small
//               decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lam_pkg;

  // lam_control[8] values
  localparam logic LAM_STORE = 1'b1;
  localparam logic LAM_LOAD  = 1'b0;

  // funct3 access-size codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } lam_state_e;

  // Stores only have signed-size encodings; loads also accept BU/HU.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
    logic mis;
    mis = 1'b0;
    if ((f3 == F3_H) || (f3 == F3_HU)) begin
      mis = a_lo[0];
    end else if (f3 == F3_W) begin
      mis = (a_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lam_align.sv
`default_nettype none
// ============================================================================
// Module      : lam_align
// Description : Combinational byte-lane steering for stores and byte/halfword
//               extraction with sign/zero extension for loads.
//               Ports: is_store, funct3, addr_lo (addr[1:0]), store_data,
//               rdata -> be, wdata, load_data.
//               Sub-word offsets below the access size are ignored, so a
//               misaligned access falls back to the aligned boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module lam_align
  import lam_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'd0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'd0, sel_half};
      default: load_data = rdata;
    endcase
  end

  // Loads always read the whole word; only stores narrow the enables.
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_H: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lam_unit.sv
`default_nettype none
// ============================================================================
// Module      : lam_unit
// Description : Load/store unit. Accepts one request from the decoder, runs a
//               single req/ack word transaction on the data bus and issues a
//               one-cycle register writeback for loads.
//               Ports: clk, reset, lam_new, lam_control[8:0], addr, store_data
//               -> busy, err; mem_req/we/addr/be/wdata <-> mem_ack/rdata;
//               wb_en, wb_sel, wb_data.
//               Optional macro LAM_MISALIGN_TRAP_EN: misaligned requests are
//               rejected with err and reported on misalign_addr.
// Revision    : 1.0 - initial release
// ============================================================================
module lam_unit
  import lam_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lam_new,
  input  logic [8:0]  lam_control,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_sel,
  output logic [31:0] wb_data
`ifdef LAM_MISALIGN_TRAP_EN
  ,
  output logic [31:0] misalign_addr
`endif
);

  localparam logic [TO_CNT_W-1:0] TO_LAST =
      TO_CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic [TO_CNT_W-1:0] TO_ONE  = {{(TO_CNT_W-1){1'b0}}, 1'b1};

  lam_state_e          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         sdata_q, sdata_d;
  logic [8:0]          ctrl_q, ctrl_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                err_q, err_d;
  logic [31:0]         wbd_q, wbd_d;
`ifdef LAM_MISALIGN_TRAP_EN
  logic [31:0]         mis_q, mis_d;
`endif

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  lam_align u_align (
    .is_store   (ctrl_q[8] == LAM_STORE),
    .funct3     (ctrl_q[7:5]),
    .addr_lo    (addr_q[1:0]),
    .store_data (sdata_q),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    ctrl_d   = ctrl_q;
    to_cnt_d = to_cnt_q;
    err_d    = 1'b0;
    wbd_d    = wbd_q;
`ifdef LAM_MISALIGN_TRAP_EN
    mis_d    = mis_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (lam_new) begin
          if (!f3_legal(lam_control[8] == LAM_STORE, lam_control[7:5])) begin
            err_d = 1'b1;
`ifdef LAM_MISALIGN_TRAP_EN
          end else if (f3_misaligned(lam_control[7:5], addr[1:0])) begin
            err_d = 1'b1;
            mis_d = addr;
`endif
          end else begin
            addr_d   = addr;
            sdata_d  = store_data;
            ctrl_d   = lam_control;
            to_cnt_d = '0;
            state_d  = ST_REQ;
`ifdef LAM_MISALIGN_TRAP_EN
            mis_d    = '0;
`endif
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (ctrl_q[8] == LAM_LOAD) begin
            wbd_d   = al_load;
            state_d = ST_WB;
          end else begin
            state_d = ST_IDLE;
          end
        end else if ((MEM_TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      sdata_q  <= '0;
      ctrl_q   <= '0;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
      wbd_q    <= '0;
`ifdef LAM_MISALIGN_TRAP_EN
      mis_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      ctrl_q   <= ctrl_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
      wbd_q    <= wbd_d;
`ifdef LAM_MISALIGN_TRAP_EN
      mis_q    <= mis_d;
`endif
    end
  end

  // Bus and writeback fields are forced to zero outside their active state
  // so an idle unit presents an all-zero interface.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    err       = err_q;
    mem_req   = (state_q == ST_REQ);
    mem_we    = mem_req && (ctrl_q[8] == LAM_STORE);
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_be    = mem_req ? al_be : 4'b0000;
    mem_wdata = mem_we ? al_wdata : 32'd0;
    wb_en     = (state_q == ST_WB) && (ctrl_q[4:0] != 5'd0);
    wb_sel    = (state_q == ST_WB) ? ctrl_q[4:0] : 5'd0;
    wb_data   = (state_q == ST_WB) ? wbd_q : 32'd0;
  end

`ifdef LAM_MISALIGN_TRAP_EN
  assign misalign_addr = mis_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lam_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_lam_unit
// Description : Directed self-checking bench for lam_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lam_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        lam_new;
  logic [8:0]  lam_control;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
`ifdef LAM_MISALIGN_TRAP_EN
  logic [31:0] misalign_addr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lam_unit #(.MEM_TIMEOUT(16), .TO_CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .lam_new     (lam_new),
    .lam_control (lam_control),
    .addr        (addr),
    .store_data  (store_data),
    .busy        (busy),
    .err         (err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .wb_en       (wb_en),
    .wb_sel      (wb_sel),
    .wb_data     (wb_data)
`ifdef LAM_MISALIGN_TRAP_EN
    ,
    .misalign_addr (misalign_addr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle request; returns in the cycle after acceptance.
  task automatic start(input logic st, input logic [2:0] f3, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] d);
    lam_new     = 1'b1;
    lam_control = {st, f3, r};
    addr        = a;
    store_data  = d;
    tick();
    lam_new     = 1'b0;
  endtask

  // Acknowledge in the current cycle with the given read data.
  task automatic ack(input logic [31:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
  endtask

  int n_req;
  int n_err;
  int n_wb;

  initial begin
    reset = 1'b1; lam_new = 1'b0; lam_control = '0; addr = '0;
    store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_req",     {31'd0, mem_req}, 32'd0);
    chk("rst_err",     {31'd0, err},     32'd0);
    chk("rst_wb_en",   {31'd0, wb_en},   32'd0);
    chk("rst_addr",    mem_addr,         32'd0);
    chk("rst_be",      {28'd0, mem_be},  32'd0);
    chk("rst_wb_data", wb_data,          32'd0);

    // SW 0x100, ack after 2 cycles: busy for 3 cycles
    start(1'b1, 3'b010, 5'd2, 32'h100, 32'hDEADBEEF);
    chk("sw_req",   {31'd0, mem_req}, 32'd1);
    chk("sw_we",    {31'd0, mem_we},  32'd1);
    chk("sw_addr",  mem_addr,         32'h100);
    chk("sw_be",    {28'd0, mem_be},  32'hF);
    chk("sw_wdata", mem_wdata,        32'hDEADBEEF);
    chk("sw_busy1", {31'd0, busy},    32'd1);
    tick();
    chk("sw_busy2", {31'd0, busy},    32'd1);
    chk("sw_hold",  mem_addr,         32'h100);
    tick();
    chk("sw_busy3", {31'd0, busy},    32'd1);
    chk("sw_wb3",   {31'd0, wb_en},   32'd0);
    ack(32'd0);
    chk("sw_done",  {31'd0, busy},    32'd0);
    chk("sw_nowb",  {31'd0, wb_en},   32'd0);

    // LB rd=5 at 0x203: latency T0 request, T1 mem_req, T2 wb_en
    start(1'b0, 3'b000, 5'd5, 32'h203, 32'd0);
    chk("lb_req",  {31'd0, mem_req}, 32'd1);
    chk("lb_we",   {31'd0, mem_we},  32'd0);
    chk("lb_be",   {28'd0, mem_be},  32'hF);
    chk("lb_addr", mem_addr,         32'h200);
    ack(32'h80FF_1234);
    chk("lb_wb_en",  {31'd0, wb_en},  32'd1);
    chk("lb_wb_sel", {27'd0, wb_sel}, 32'd5);
    chk("lb_wb_data", wb_data,        32'hFFFFFF80);
    tick();
    chk("lb_wb_once", {31'd0, wb_en}, 32'd0);
    chk("lb_idle",    {31'd0, busy},  32'd0);

    // LBU same address
    start(1'b0, 3'b100, 5'd5, 32'h203, 32'd0);
    ack(32'h80FF_1234);
    chk("lbu_wb_data", wb_data, 32'h00000080);
    tick();

    // SH at 0x302
    start(1'b1, 3'b001, 5'd1, 32'h302, 32'h0000ABCD);
    chk("sh_addr",  mem_addr,        32'h300);
    chk("sh_be",    {28'd0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata,       32'hABCDABCD);
    ack(32'd0);
    chk("sh_done",  {31'd0, busy},   32'd0);

    // SB at 0x101
    start(1'b1, 3'b000, 5'd1, 32'h101, 32'h0000_0055);
    chk("sb_be",    {28'd0, mem_be}, 32'h2);
    chk("sb_wdata", mem_wdata,       32'h55555555);
    ack(32'd0);

    // LHU / LH
    start(1'b0, 3'b101, 5'd9, 32'h302, 32'd0);
    ack(32'hABCD_0000);
    chk("lhu_wb_data", wb_data, 32'h0000ABCD);
    tick();
    start(1'b0, 3'b001, 5'd9, 32'h300, 32'd0);
    ack(32'h0000_8001);
    chk("lh_wb_data", wb_data, 32'hFFFF8001);
    tick();

    // Timeout: LW with no ack
    start(1'b0, 3'b010, 5'd3, 32'h400, 32'd0);
    n_req = 0; n_err = 0; n_wb = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) n_req++;
      if (err)     n_err++;
      if (wb_en)   n_wb++;
      tick();
    end
    chk("to_req_cycles", n_req, 32'd16);
    chk("to_err_pulses", n_err, 32'd1);
    chk("to_no_wb",      n_wb,  32'd0);
    chk("to_busy",       {31'd0, busy}, 32'd0);

    // Illegal funct3
    start(1'b0, 3'b011, 5'd3, 32'h400, 32'd0);
    chk("ill_err",  {31'd0, err},     32'd1);
    chk("ill_req",  {31'd0, mem_req}, 32'd0);
    chk("ill_busy", {31'd0, busy},    32'd0);
    tick();
    chk("ill_err_once", {31'd0, err}, 32'd0);

    // lam_new while busy is ignored
    start(1'b0, 3'b010, 5'd7, 32'h500, 32'd0);
    lam_new = 1'b1; lam_control = {1'b1, 3'b010, 5'd8};
    addr = 32'h600; store_data = 32'h11111111;
    tick();
    lam_new = 1'b0;
    chk("busy_ign_addr", mem_addr,        32'h500);
    chk("busy_ign_we",   {31'd0, mem_we}, 32'd0);
    ack(32'h1234_5678);
    chk("busy_wb_data", wb_data,          32'h12345678);
    chk("busy_wb_sel",  {27'd0, wb_sel},  32'd7);
    tick();
    chk("busy_noq", {31'd0, mem_req}, 32'd0);
    tick();
    chk("busy_noq2", {31'd0, mem_req}, 32'd0);

    // LW rd=0: bus read happens, no writeback strobe
    start(1'b0, 3'b010, 5'd0, 32'h104, 32'd0);
    chk("rd0_req", {31'd0, mem_req}, 32'd1);
    ack(32'hCAFEF00D);
    chk("rd0_busy", {31'd0, busy},  32'd1);
    chk("rd0_wb",   {31'd0, wb_en}, 32'd0);
    tick();
    chk("rd0_idle", {31'd0, busy},  32'd0);

    // Reset while in REQ
    start(1'b0, 3'b010, 5'd4, 32'h700, 32'd0);
    chk("rreq_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rreq_req0",  {31'd0, mem_req}, 32'd0);
    chk("rreq_busy0", {31'd0, busy},    32'd0);
    chk("rreq_addr0", mem_addr,         32'd0);
    chk("rreq_wb0",   {31'd0, wb_en},   32'd0);
    tick();

    // Misaligned word access
`ifdef LAM_MISALIGN_TRAP_EN
    start(1'b0, 3'b010, 5'd6, 32'h102, 32'd0);
    chk("mis_err",  {31'd0, err},     32'd1);
    chk("mis_req",  {31'd0, mem_req}, 32'd0);
    chk("mis_addr", misalign_addr,    32'h102);
    tick();
    chk("mis_req2",  {31'd0, mem_req}, 32'd0);
    chk("mis_hold",  misalign_addr,    32'h102);
`else
    start(1'b1, 3'b010, 5'd6, 32'h102, 32'h0BADC0DE);
    chk("mis_addr", mem_addr,        32'h100);
    chk("mis_be",   {28'd0, mem_be}, 32'hF);
    chk("mis_err",  {31'd0, err},    32'd0);
    ack(32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lam_unit.md
Name: lam_unit

Overview:
- Load/store memory unit sitting directly downstream of the instruction decoder.
- Consumes lam_new and the 9-bit lam_control word {ld/st bit, funct3, reg index}, plus the ALU-computed effective address and the store operand.
- Runs one word-wide request/acknowledge transaction on the data-memory bus.
- Steers byte lanes, sign/zero-extends load data and issues a one-cycle register-file writeback; busy stalls upstream while a transaction is in flight.

Parameters:
- MEM_TIMEOUT, 16, cycles to wait for mem_ack before aborting with err; 0 disables the watchdog.
- TO_CNT_W, 5, timeout counter width; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- lam_new  in  1  one-cycle pulse: new load/store request (decoder asserts it for both loads and stores).
- lam_control  in  9  [8]=1 store / 0 load, [7:5]=funct3, [4:0]=rd for loads, rs2 for stores.
- addr  in  32  effective address from ALU.
- store_data  in  32  rs2 value; sampled with the request.
- busy  out  1  high while state != IDLE.
- err  out  1  one-cycle pulse on illegal funct3 or timeout.
- mem_req  out  1  bus request; held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address, bits [1:0] = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-steered store data.
- mem_ack  in  1  bus acknowledge; read data valid in the same cycle.
- mem_rdata  in  32  read word.
- wb_en  out  1  one-cycle register write strobe.
- wb_sel  out  5  destination register.
- wb_data  out  32  extended load result.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0, including mem_req, wb_en, err and all buses. Reset mid-transaction aborts immediately; mem_req drops the next edge.
- States: IDLE, REQ, WB.
- IDLE:
  - lam_new=1 with legal funct3: latch addr, store_data and lam_control, go to REQ. mem_req=1 from the next cycle.
  - Legal funct3: loads LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010.
  - Illegal funct3: pulse err for 1 cycle, no bus access, no writeback, stay IDLE.
- REQ:
  - Outputs held stable until mem_ack.
  - On mem_ack, load: capture extended data, go to WB.
  - On mem_ack, store: go to IDLE.
  - The timeout counter resets on REQ entry. If it reaches MEM_TIMEOUT with no ack: drop mem_req, pulse err, go to IDLE, no writeback.
- WB: wb_en=1 for exactly one cycle with wb_sel/wb_data, then IDLE. If rd=0, wb_en stays 0 but the transaction still completes.
- Latency (load, ack in the first REQ cycle): request at T0, mem_req at T1, wb_en at T2. Store with immediate ack: busy for 1 cycle.
- lam_new while busy=1 is ignored; upstream must stall on busy. No queuing.
- Store lanes:
  - SB: be=0001<<addr[1:0], data byte replicated to all lanes.
  - SH: be=0011<<(addr[1]*2), halfword replicated.
  - SW: be=1111.
- Load extension:
  - Select byte addr[1:0] or halfword addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Misalignment (default): addr[1:0] is ignored for LW/SW, and addr[0] for LH/LHU/SH; the access is forced to the aligned boundary.
- mem_be=0000 on loads is not allowed; loads drive 1111.

Optional Feature:
- Macro: LAM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request (halfword with addr[0]=1, word with addr[1:0]!=0) makes no bus access.
  - Pulses err and drives added output misalign_addr[31:0] with the faulting address, held until the next accepted request.
  - Stays IDLE.
- Undefined: the port does not exist; silent align-down as above.

Decomposition:
- Package lam_pkg:
  - LAM_STORE/LAM_LOAD bit values.
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding for IDLE/REQ/WB.
- Sub-module lam_align: combinational store-lane steering (mem_be, mem_wdata) and load extraction/extension (wb_data) from funct3 and addr[1:0]. The FSM stays in lam_unit.

Test Plan:
- SW at 0x100, data 0xDEADBEEF, ack after 2 cycles -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF, mem_we=1, no wb_en, busy for 3 cycles.
- LB rd=5 at 0x203, rdata=0x80FF_1234 -> be=1111, wb_sel=5, wb_data=0xFFFFFF80. LBU same -> 0x00000080.
- SH at 0x302, data 0x0000ABCD -> mem_addr=0x300, be=1100, wdata=0xABCDABCD. LHU 0x302 with rdata 0xABCD0000 -> 0x0000ABCD.
- Load with mem_ack never asserted, MEM_TIMEOUT=16 -> mem_req falls after 16 REQ cycles, err pulses once, no wb_en, busy clears.
- lam_new with funct3=011 -> err pulse, mem_req stays 0. lam_new while busy -> ignored. LW rd=0 -> bus read occurs, wb_en stays 0.
- Reset asserted in REQ -> all outputs 0 next edge; with LAM_MISALIGN_TRAP_EN, LW at 0x102 -> err=1, misalign_addr=0x102, mem_req never asserted.
